// File: rtl/ntt_job_sequencer.sv
// Sequences one NTT job through kernel_top: mode/decode, coefficient and paced load streams from a
// single host stream, then forwards the kernel result stream and checks its length against sw_lst.
module ntt_job_sequencer #(
    parameter int unsigned DW         = 128,
    parameter int unsigned COEF_BEATS = 64,
    parameter int unsigned LD_BEATS   = 128,
    parameter int unsigned OUT_BEATS  = 128,
    parameter int unsigned LD_GAP     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    start_mode,
    output logic          busy,
    output logic          done,
    output logic          err,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [DW-1:0] in_dat,
    output logic [7:0]    mode,
    output logic          decode,
    output logic          coef_vld,
    input  logic          coef_rdy,
    output logic [DW-1:0] coef_dat,
    output logic          ld_vld,
    input  logic          ld_rdy,
    output logic [DW-1:0] ld_dat,
    input  logic          sw_vld,
    output logic          sw_rdy,
    input  logic [DW-1:0] sw_dat,
    input  logic          sw_lst,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [DW-1:0] out_dat,
    output logic          out_lst
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StDecode = 3'd1;
    localparam logic [2:0] StCoef   = 3'd2;
    localparam logic [2:0] StLoad   = 3'd3;
    localparam logic [2:0] StDrain  = 3'd4;
    localparam logic [2:0] StFin    = 3'd5;

    localparam logic [7:0] CoefLast = 8'(COEF_BEATS - 1);
    localparam logic [7:0] LdLast   = 8'(LD_BEATS - 1);
    localparam logic [7:0] OutLast  = 8'(OUT_BEATS - 1);
    localparam logic [7:0] GapLast  = 8'(LD_GAP - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] mode_q, mode_d;
    logic       err_q, err_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] gap_q, gap_d;
    logic       gate;
    logic       cnt_at_out_last;

    assign gate            = (gap_q == 8'd0);
    assign cnt_at_out_last = (cnt_q == OutLast);

    // Data paths are pure pass-through; only the handshakes are steered by state.
    assign coef_dat = in_dat;
    assign ld_dat   = in_dat;
    assign out_dat  = sw_dat;

    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StFin);
    assign decode = (state_q == StDecode);
    assign mode   = mode_q;
    assign err    = err_q;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        gap_d    = (gap_q != 8'd0) ? gap_q - 8'd1 : gap_q;
        in_rdy   = 1'b0;
        coef_vld = 1'b0;
        ld_vld   = 1'b0;
        sw_rdy   = 1'b0;
        out_vld  = 1'b0;
        out_lst  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d  = start_mode;
                    err_d   = 1'b0;
                    cnt_d   = 8'd0;
                    gap_d   = 8'd0;
                    state_d = StDecode;
                end
            end
            StDecode: state_d = StCoef;
            StCoef: begin
                coef_vld = in_vld;
                in_rdy   = coef_rdy;
                if (in_vld && coef_rdy) begin
                    if (cnt_q == CoefLast) begin
                        cnt_d   = 8'd0;
                        state_d = StLoad;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            StLoad: begin
                ld_vld = in_vld & gate;
                in_rdy = ld_rdy & gate;
                if (in_vld && ld_rdy && gate) begin
                    gap_d = GapLast;
                    if (cnt_q == LdLast) begin
                        cnt_d   = 8'd0;
                        state_d = StDrain;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            StDrain: begin
                out_vld = sw_vld;
                sw_rdy  = out_rdy;
                out_lst = cnt_at_out_last;
                if (sw_vld && out_rdy) begin
                    // A length mismatch is exactly one of the two end conditions firing alone.
                    if (sw_lst || cnt_at_out_last) begin
                        err_d   = err_q | (sw_lst ^ cnt_at_out_last);
                        cnt_d   = 8'd0;
                        state_d = StFin;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            mode_q  <= 8'd0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
            gap_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
        end
    end

endmodule

// File: tb/tb_ntt_job_sequencer.sv
// Directed bench for ntt_job_sequencer: host/kernel stream models around the default build plus an
// LD_GAP=1 build for back-to-back load pacing.
module tb_ntt_job_sequencer;

    logic         clk = 1'b0;
    logic         rst, start, in_vld, coef_rdy, ld_rdy, sw_vld, sw_lst, out_rdy;
    logic [7:0]   start_mode;
    logic [127:0] in_dat, sw_dat;
    logic         busy, done, err, in_rdy, decode, coef_vld, ld_vld, sw_rdy, out_vld, out_lst;
    logic [7:0]   mode;
    logic [127:0] coef_dat, ld_dat, out_dat;

    logic         g_rst, g_start, g_in_vld;
    logic [127:0] g_in_dat;
    logic         g_busy, g_done, g_err, g_in_rdy, g_decode, g_coef_vld, g_ld_vld;
    logic         g_sw_rdy, g_out_vld, g_out_lst;
    logic [7:0]   g_mode;
    logic [127:0] g_coef_dat, g_ld_dat, g_out_dat;

    int errors = 0;
    int checks = 0;

    int o_decode, o_done, o_coef, o_ld, o_out, o_bad_coef, o_bad_ld, o_bad_out, o_rdy_viol;
    int o_gap_min, o_mode_bad, o_busy_bad, o_lst_cnt, o_lst_at, o_timeout;

    always #5 clk = ~clk;

    ntt_job_sequencer u_dut (
        .clk(clk), .rst(rst), .start(start), .start_mode(start_mode),
        .busy(busy), .done(done), .err(err),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_dat(in_dat),
        .mode(mode), .decode(decode),
        .coef_vld(coef_vld), .coef_rdy(coef_rdy), .coef_dat(coef_dat),
        .ld_vld(ld_vld), .ld_rdy(ld_rdy), .ld_dat(ld_dat),
        .sw_vld(sw_vld), .sw_rdy(sw_rdy), .sw_dat(sw_dat), .sw_lst(sw_lst),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat), .out_lst(out_lst)
    );

    ntt_job_sequencer #(.LD_GAP(1)) u_dut_g1 (
        .clk(clk), .rst(g_rst), .start(g_start), .start_mode(8'h0A),
        .busy(g_busy), .done(g_done), .err(g_err),
        .in_vld(g_in_vld), .in_rdy(g_in_rdy), .in_dat(g_in_dat),
        .mode(g_mode), .decode(g_decode),
        .coef_vld(g_coef_vld), .coef_rdy(1'b1), .coef_dat(g_coef_dat),
        .ld_vld(g_ld_vld), .ld_rdy(1'b1), .ld_dat(g_ld_dat),
        .sw_vld(1'b0), .sw_rdy(g_sw_rdy), .sw_dat(128'd0), .sw_lst(1'b0),
        .out_vld(g_out_vld), .out_rdy(1'b1), .out_dat(g_out_dat), .out_lst(g_out_lst)
    );

    // Lane k of beat n carries 8n+k; kernel results use beat numbers from 500 up.
    function automatic logic [127:0] beat(input int n);
        logic [127:0] r;
        for (int k = 0; k < 8; k++) r[16*k +: 16] = 16'(8 * n + k);
        return r;
    endfunction

    task automatic run_job(input logic [7:0] m, input bit coef_tog, input bit out_bp,
                           input int lst_idx, input int abort_ld, input int poke_ld);
        int host_idx, sw_idx, last_ld;
        bit fin;
        host_idx = 0; sw_idx = 0; last_ld = -1000; fin = 0;
        o_decode = 0; o_done = 0; o_coef = 0; o_ld = 0; o_out = 0; o_bad_coef = 0;
        o_bad_ld = 0; o_bad_out = 0; o_rdy_viol = 0; o_gap_min = 1 << 30; o_mode_bad = 0;
        o_busy_bad = 0; o_lst_cnt = 0; o_lst_at = -1; o_timeout = 0;
        for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
            @(negedge clk);
            if (abort_ld >= 0 && o_ld == abort_ld) break;
            start      = (cyc == 0) || (poke_ld >= 0 && o_ld == poke_ld);
            start_mode = (cyc == 0) ? m : 8'h55;
            in_vld     = host_idx < 192;
            in_dat     = beat(host_idx);
            coef_rdy   = coef_tog ? (cyc % 2 == 1) : 1'b1;
            ld_rdy     = 1'b1;
            sw_vld     = sw_idx < 128;
            sw_dat     = beat(500 + sw_idx);
            sw_lst     = (sw_idx == lst_idx);
            out_rdy    = out_bp ? ((cyc / 5) % 2 == 1) : 1'b1;
            #1;
            if (decode) o_decode++;
            if (done) begin o_done++; fin = 1; end
            if (cyc > 0 && !busy) o_busy_bad++;
            if (cyc > 0 && mode !== m) o_mode_bad++;
            if (coef_vld && in_rdy !== coef_rdy) o_rdy_viol++;
            if (in_rdy && !coef_vld && !ld_vld) o_rdy_viol++;
            if ((out_vld || sw_rdy) && o_ld < 128) o_bad_out++;
            if (coef_vld && coef_rdy) begin
                if (coef_dat !== beat(o_coef) || ld_vld) o_bad_coef++;
                o_coef++;
            end
            if (ld_vld && ld_rdy) begin
                if (ld_dat !== beat(64 + o_ld)) o_bad_ld++;
                if (cyc - last_ld < o_gap_min) o_gap_min = cyc - last_ld;
                last_ld = cyc;
                o_ld++;
            end
            if (out_vld && out_rdy) begin
                if (out_dat !== beat(500 + o_out)) o_bad_out++;
                if (out_lst) begin o_lst_cnt++; o_lst_at = o_out; end
                o_out++;
            end
            if (in_vld && in_rdy) host_idx++;
            if (sw_vld && sw_rdy) sw_idx++;
        end
        if (!fin && abort_ld < 0) o_timeout = 1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        in_vld = 1'b1; sw_vld = 1'b1; coef_rdy = 1'b1; ld_rdy = 1'b1; out_rdy = 1'b1;
        #1;
        checks++; if (mode !== 8'h00) begin errors++; $display("FAIL reset mode: got %h want 00", mode); end
        checks++; if ({busy, done, err, decode} !== 4'b0) begin errors++;
            $display("FAIL reset status: got %b want 0000", {busy, done, err, decode}); end
        checks++; if ({in_rdy, sw_rdy, coef_vld, ld_vld, out_vld} !== 5'b0) begin errors++;
            $display("FAIL reset handshakes: got %b want 00000", {in_rdy, sw_rdy, coef_vld, ld_vld, out_vld}); end
    endtask

    task automatic test_nominal();
        run_job(8'h0A, 1'b0, 1'b0, 127, -1, -1);
        checks++; if (o_timeout !== 0) begin errors++; $display("FAIL nominal timeout: got %0d want 0", o_timeout); end
        checks++; if (o_decode !== 1) begin errors++; $display("FAIL nominal decode cycles: got %0d want 1", o_decode); end
        checks++; if (o_coef !== 64 || o_bad_coef !== 0) begin errors++;
            $display("FAIL nominal coef: got %0d beats %0d bad want 64 0", o_coef, o_bad_coef); end
        checks++; if (o_ld !== 128 || o_bad_ld !== 0) begin errors++;
            $display("FAIL nominal ld: got %0d beats %0d bad want 128 0", o_ld, o_bad_ld); end
        checks++; if (o_gap_min !== 8) begin errors++; $display("FAIL nominal ld gap: got %0d want 8", o_gap_min); end
        checks++; if (o_out !== 128 || o_bad_out !== 0) begin errors++;
            $display("FAIL nominal out: got %0d beats %0d bad want 128 0", o_out, o_bad_out); end
        checks++; if (o_lst_cnt !== 1 || o_lst_at !== 127) begin errors++;
            $display("FAIL nominal out_lst: got %0d at %0d want 1 at 127", o_lst_cnt, o_lst_at); end
        checks++; if (o_done !== 1 || err !== 1'b0) begin errors++;
            $display("FAIL nominal done/err: got %0d/%b want 1/0", o_done, err); end
        checks++; if (o_busy_bad !== 0 || o_mode_bad !== 0 || o_rdy_viol !== 0) begin errors++;
            $display("FAIL nominal busy/mode/rdy: got %0d/%0d/%0d want 0/0/0", o_busy_bad, o_mode_bad, o_rdy_viol); end
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++;
            $display("FAIL nominal idle after done: got %b%b want 00", busy, done); end
    endtask

    task automatic test_backpressure();
        run_job(8'h0A, 1'b1, 1'b1, 127, -1, -1);
        checks++; if (o_coef !== 64 || o_bad_coef !== 0) begin errors++;
            $display("FAIL bp coef: got %0d beats %0d bad want 64 0", o_coef, o_bad_coef); end
        checks++; if (o_rdy_viol !== 0) begin errors++; $display("FAIL bp in_rdy: got %0d violations want 0", o_rdy_viol); end
        checks++; if (o_out !== 128 || o_bad_out !== 0) begin errors++;
            $display("FAIL bp out: got %0d beats %0d bad want 128 0", o_out, o_bad_out); end
        checks++; if (o_done !== 1 || err !== 1'b0) begin errors++;
            $display("FAIL bp done/err: got %0d/%b want 1/0", o_done, err); end
    endtask

    task automatic test_early_lst();
        run_job(8'h21, 1'b0, 1'b0, 99, -1, -1);
        checks++; if (o_out !== 100 || o_bad_out !== 0) begin errors++;
            $display("FAIL early out: got %0d beats %0d bad want 100 0", o_out, o_bad_out); end
        checks++; if (o_lst_cnt !== 0) begin errors++; $display("FAIL early out_lst: got %0d want 0", o_lst_cnt); end
        checks++; if (o_done !== 1 || err !== 1'b1) begin errors++;
            $display("FAIL early done/err: got %0d/%b want 1/1", o_done, err); end
    endtask

    task automatic test_missing_lst();
        run_job(8'h22, 1'b0, 1'b0, -1, -1, -1);
        checks++; if (o_out !== 128 || o_bad_out !== 0) begin errors++;
            $display("FAIL missing out: got %0d beats %0d bad want 128 0", o_out, o_bad_out); end
        checks++; if (o_lst_cnt !== 1 || o_lst_at !== 127) begin errors++;
            $display("FAIL missing out_lst: got %0d at %0d want 1 at 127", o_lst_cnt, o_lst_at); end
        checks++; if (o_done !== 1 || err !== 1'b1) begin errors++;
            $display("FAIL missing done/err: got %0d/%b want 1/1", o_done, err); end
    endtask

    task automatic test_start_ignored_and_abort();
        int dones;
        run_job(8'h0A, 1'b0, 1'b0, 127, 40, 20);
        checks++; if (o_ld !== 40 || o_done !== 0 || o_decode !== 1) begin errors++;
            $display("FAIL abort pre: got ld=%0d done=%0d dec=%0d want 40 0 1", o_ld, o_done, o_decode); end
        checks++; if (o_mode_bad !== 0 || o_busy_bad !== 0) begin errors++;
            $display("FAIL start in load: got mode_bad=%0d busy_bad=%0d want 0 0", o_mode_bad, o_busy_bad); end
        start = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        checks++; if ({busy, done, err, decode, in_rdy, coef_vld, ld_vld, sw_rdy, out_vld, out_lst} !== 10'b0
                      || mode !== 8'h00) begin errors++;
            $display("FAIL abort outputs: got %b mode %h want 0 00",
                     {busy, done, err, decode, in_rdy, coef_vld, ld_vld, sw_rdy, out_vld, out_lst}, mode); end
        dones = 0;
        for (int i = 0; i < 20; i++) begin @(negedge clk); #1; if (done) dones++; end
        checks++; if (dones !== 0) begin errors++; $display("FAIL abort done: got %0d want 0", dones); end
        run_job(8'h3C, 1'b0, 1'b0, 127, -1, -1);
        checks++; if (o_ld !== 128 || o_out !== 128 || o_bad_ld !== 0 || o_bad_out !== 0) begin errors++;
            $display("FAIL rerun streams: got ld=%0d out=%0d bad=%0d/%0d", o_ld, o_out, o_bad_ld, o_bad_out); end
        checks++; if (o_done !== 1 || err !== 1'b0) begin errors++;
            $display("FAIL rerun done/err: got %0d/%b want 1/0", o_done, err); end
    endtask

    task automatic test_back_to_back_gap1();
        int n_ld, first, last, bad, idx;
        n_ld = 0; first = -1; last = -1; bad = 0; idx = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            g_start  = (cyc == 0);
            g_in_vld = 1'b1;
            g_in_dat = beat(idx);
            #1;
            if (g_ld_vld) begin
                if (g_ld_dat !== beat(64 + n_ld)) bad++;
                if (first < 0) first = cyc;
                last = cyc;
                n_ld++;
            end
            if (g_in_vld && g_in_rdy) idx++;
        end
        checks++; if (n_ld !== 128 || bad !== 0) begin errors++;
            $display("FAIL gap1 ld: got %0d beats %0d bad want 128 0", n_ld, bad); end
        checks++; if (last - first !== 127) begin errors++;
            $display("FAIL gap1 span: got %0d want 127", last - first); end
        g_start = 1'b0; g_rst = 1'b1;
        @(negedge clk); g_rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; g_rst = 1'b1; start = 1'b0; g_start = 1'b0; start_mode = 8'h00;
        in_vld = 1'b0; in_dat = '0; coef_rdy = 1'b0; ld_rdy = 1'b0; sw_vld = 1'b0;
        sw_dat = '0; sw_lst = 1'b0; out_rdy = 1'b0; g_in_vld = 1'b0; g_in_dat = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0; g_rst = 1'b0;
        test_reset();
        test_nominal();
        test_backpressure();
        test_early_lst();
        test_missing_lst();
        test_start_ignored_and_abort();
        test_back_to_back_gap1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ntt_job_sequencer.md
Name: ntt_job_sequencer

Overview:
- Sequences one NTT job through kernel_top: latches the mode and issues the decode pulse, then steers a single 128-bit host input stream into the coefficient port (64 beats) and the load port (128 beats, paced).
- Forwards the kernel's result stream to the host and checks its length against sw_lst.
- Sits between the host/DMA stream and kernel_top, replacing the hand sequencing done by the kernel-level bench.

Parameters:
- DW, 128, stream data width (8 x 16-bit lanes).
- COEF_BEATS, 64, number of coefficient beats per job.
- LD_BEATS, 128, number of load beats per job. Order is low(i), high(i) interleaved; the host supplies the stream already in that order.
- OUT_BEATS, 128, expected number of result beats per job.
- LD_GAP, 8, minimum cycles between consecutive ld handshakes (1 = back-to-back).

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- start  in  1  job start pulse; sampled only in IDLE
- start_mode  in  8  kernel mode for the job; captured with start
- busy  out  1  high from the accepted start until the done cycle inclusive
- done  out  1  one-cycle pulse at job end
- err  out  1  sticky length error; cleared by an accepted start or by rst
- in_vld  in  1  host input valid
- in_rdy  out  1  host input ready
- in_dat  in  DW  host input data
- mode  out  8  to kernel mode
- decode  out  1  to kernel decode
- coef_vld  out  1  to kernel coefficient stream valid
- coef_rdy  in  1  kernel coefficient stream ready
- coef_dat  out  DW  kernel coefficient stream data
- ld_vld  out  1  to kernel load stream valid
- ld_rdy  in  1  kernel load stream ready
- ld_dat  out  DW  kernel load stream data
- sw_vld  in  1  from kernel result stream valid
- sw_rdy  out  1  kernel result stream ready
- sw_dat  in  DW  kernel result stream data
- sw_lst  in  1  kernel last-beat flag
- out_vld  out  1  host result stream valid
- out_rdy  in  1  host result stream ready
- out_dat  out  DW  host result stream data
- out_lst  out  1  host result last-beat flag

Behaviour:
- Reset: state = IDLE. mode=0, decode=0, busy=0, done=0, err=0. All vld/rdy outputs = 0. Counters and gap_cnt = 0.
- rst asserted mid-job aborts the job immediately. No done pulse. Beats already in flight are not replayed.
- Handshakes are valid/ready: a transfer occurs on a clk edge with vld&rdy=1. Data paths are combinational pass-through (no extra latency).
- IDLE: busy=0, in_rdy=0, sw_rdy=0. On start=1: latch start_mode into mode, clear err, go to DECODE.
- start is ignored while busy.
- DECODE (exactly 1 cycle): decode=1, then go to COEF. mode holds its value until the next accepted start.
- COEF:
  - coef_vld=in_vld, in_rdy=coef_rdy, coef_dat=in_dat.
  - cnt increments per transfer.
  - On the transfer with cnt==COEF_BEATS-1: cnt:=0, go to LOAD.
- LOAD:
  - gate = (gap_cnt==0).
  - ld_vld=in_vld&gate, in_rdy=ld_rdy&gate, ld_dat=in_dat.
  - On each transfer, gap_cnt:=LD_GAP-1; otherwise gap_cnt decrements while nonzero.
  - With LD_GAP=8, handshakes are at least 8 cycles apart.
  - On the transfer with cnt==LD_BEATS-1: cnt:=0, go to DRAIN.
- DRAIN:
  - out_vld=sw_vld, sw_rdy=out_rdy, out_dat=sw_dat.
  - out_lst=(cnt==OUT_BEATS-1), generated from the internal count, not from sw_lst.
  - cnt increments per transfer.
  - Job ends on the first transfer where either sw_lst=1 or cnt==OUT_BEATS-1.
  - If exactly one of those two conditions holds on the ending beat, err:=1.
  - On job end go to FIN.
- FIN (1 cycle): done=1, busy=1, then go to IDLE.
- in_rdy=0 in IDLE, DECODE, DRAIN and FIN. Host beats offered in those states stall.
- sw_rdy=0 outside DRAIN. Early kernel output is backpressured.
- Counters are 8 bits wide; parameters must be ≤256.

Test Plan:
- Nominal job: start with start_mode=8'h0A; host streams 64 coef beats then 128 ld beats (lane k of beat n = 8n+k); kernel returns 128 beats with sw_lst on beat 127 -> decode high exactly 1 cycle, 64 coef and 128 ld transfers in order, ld handshakes ≥8 cycles apart, out_lst only on beat 127, done pulse, err=0.
- Backpressure: coef_rdy toggles every other cycle, out_rdy low for 5-cycle bursts -> no beat lost or duplicated, data order preserved, in_rdy never high while coef_rdy low.
- Early sw_lst on result beat 99 -> job ends at beat 99, out_lst=0 on that beat, err=1, done pulses once.
- Missing sw_lst through beat 127 -> job ends after 128 beats, out_lst=1 on beat 127, err=1.
- start asserted during LOAD with start_mode=8'h55 -> ignored, mode stays 8'h0A. rst pulsed at ld beat 40 -> all outputs 0 next cycle, no done. A new start then runs a full clean job with err=0.
- LD_GAP=1 build: host in_vld held high -> 128 ld transfers in 128 consecutive cycles when ld_rdy=1.
